im_mem_stage: RTL

Memory-access stage controller between the IX/IM and IM/WB pipeline registers. It decodes the latched load/store controls, performs size/alignment checks, drives a request/ready data-memory port, and returns aligned and extended load data. While an access is outstanding it stalls the upstream pipeline; a watchdog aborts accesses that never complete.

---
 rtl/im_pkg.sv | 51 +++++
 rtl/im_mem_if.sv | 37 +++
 rtl/im_lane_align.sv | 41 ++++
 rtl/im_mem_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_pkg
// Description : Shared types, constants and helpers for the memory-access
//               stage: access-size codes, FSM state type, byte-lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package im_pkg;

    // Access-size encoding carried down the pipeline
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Access controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Big-endian byte enables: bit 3 is the lane at byte offset 0 (bits 31:24)
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b1000 >> addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across every lane it could land in
    function automatic logic [31:0] replicate_store(input logic [1:0]  size,
                                                    input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (size)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage : im_pkg
`default_nettype wire

// File: rtl/im_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : im_mem_if
// Description : Request/ready data-memory port between the memory-access
//               stage (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface im_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_rdata,
        output mem_ready
    );
endinterface : im_mem_if
`default_nettype wire

// File: rtl/im_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : im_lane_align
// Description : Combinational load-data alignment. Moves the addressed byte or
//               halfword lane down to bit 0 and sign- or zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module im_lane_align
    import im_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [1:0]  addr_lo,
    input  wire logic [1:0]  size,
    input  wire logic        sign_ext,
    output logic      [31:0] result
);

    logic [7:0]  w_lane8;
    logic [15:0] w_lane16;

    // Select the addressed lane (big-endian: offset 0 is the top byte) and extend
    always_comb begin
        w_lane8  = 8'h00;
        w_lane16 = 16'h0000;
        result   = rdata;
        case (addr_lo)
            2'b00:   w_lane8 = rdata[31:24];
            2'b01:   w_lane8 = rdata[23:16];
            2'b10:   w_lane8 = rdata[15:8];
            default: w_lane8 = rdata[7:0];
        endcase
        w_lane16 = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        case (size)
            SZ_BYTE: result = {{24{sign_ext & w_lane8[7]}}, w_lane8};
            SZ_HALF: result = {{16{sign_ext & w_lane16[15]}}, w_lane16};
            default: result = rdata;
        endcase
    end

endmodule : im_lane_align
`default_nettype wire

// File: rtl/im_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : im_mem_stage
// Description : Memory-access stage controller. Checks size/alignment of the
//               latched load/store, runs one request/ready transaction on the
//               data-memory port while stalling upstream, aborts on watchdog
//               expiry and returns aligned/extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module im_mem_stage
    import im_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] O_in,
    input  wire logic [31:0] B_in,
    input  wire logic [31:0] wb_data_in,
    input  wire logic [1:0]  access_size_in,
    input  wire logic        rw_in,
    input  wire logic        res_data_sel_in,
    input  wire logic        memory_sign_extend_in,
    input  wire logic        wm_data_bypass_in,
    im_mem_if.master         mem,
    output logic      [31:0] data_out,
    output logic             stall_out,
    output logic             exc_misaligned,
    output logic             bus_error
);

    // Last WAIT count before the watchdog aborts the access
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [1:0]  size_q,   size_d;
    logic        rw_q,     rw_d;
    logic        sext_q,   sext_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic        err_q,    err_d;

    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_aligned_op;
    logic [31:0] w_load_result;

    // Classify the instruction currently held in the IX/IM register
    always_comb begin
        w_mem_op     = rw_in | res_data_sel_in;
        w_misaligned = 1'b0;
        case (access_size_in)
            SZ_WORD: w_misaligned = (O_in[1:0] != 2'b00);
            SZ_HALF: w_misaligned = O_in[0];
            SZ_BYTE: w_misaligned = 1'b0;
            default: w_misaligned = 1'b1;
        endcase
        w_misaligned = w_mem_op & w_misaligned;
        w_aligned_op = w_mem_op & ~w_misaligned;
    end

    // Next-state, capture and watchdog logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        rw_d    = rw_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                err_d = 1'b0;
                if (w_aligned_op) begin
                    state_d = WAIT;
                    addr_d  = O_in;
                    size_d  = access_size_in;
                    rw_d    = rw_in;
                    sext_d  = memory_sign_extend_in;
                    wdata_d = replicate_store(access_size_in,
                                  wm_data_bypass_in ? wb_data_in : B_in);
                end
            end
            WAIT: begin
                // A completion on the same edge as expiry still counts as success
                if (mem.mem_ready) begin
                    state_d = DONE;
                    rdata_d = mem.mem_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers; async reset abandons any outstanding access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0000_0000;
            size_q  <= SZ_WORD;
            rw_q    <= 1'b0;
            sext_q  <= 1'b0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    im_lane_align u_lane_align (
        .rdata    (rdata_q),
        .addr_lo  (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (sext_q),
        .result   (w_load_result)
    );

    // Memory port is driven only from captured state; strobes qualified by req
    always_comb begin
        mem.mem_req   = (state_q == WAIT);
        mem.mem_we    = (state_q == WAIT) & rw_q;
        mem.mem_addr  = {addr_q[31:2], 2'b00};
        mem.mem_wdata = wdata_q;
        mem.mem_be    = (state_q == WAIT) ? byte_enable(size_q, addr_q[1:0]) : 4'b0000;
    end

    // Result, stall and exception outputs toward the pipeline
    always_comb begin
        stall_out      = rst_n & w_aligned_op & (state_q != DONE);
        exc_misaligned = w_misaligned;
        bus_error      = (state_q == DONE) & err_q;
        if (state_q == DONE) begin
            data_out = rw_q ? 32'h0000_0000 : w_load_result;
        end else if (w_mem_op) begin
            data_out = 32'h0000_0000;
        end else begin
            data_out = O_in;
        end
    end

endmodule : im_mem_stage
`default_nettype wire
